div_unit: RTL and testbench

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions, which the single-cycle ALU does not implement. Sits beside the ALU in the execute stage. It takes the same rs1/rs2 operands as the ALU and returns its result to the writeback mux through a valid/ready handshake. While it is busy, the hazard unit stalls the pipeline.

---
 rtl/div_unit.sv | 158 +++++++++++++++
 tb/tb_div_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; zero-divisor and signed-overflow cases finish at accept.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state_r;
  logic [4:0]      count_r;
  logic [1:0]      op_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] dvsr_r;
  logic            qsign_r;
  logic            rsign_r;
  logic [XLEN-1:0] result_r;
  logic            out_valid_r;

  logic            signed_s;
  logic            div_zero_s;
  logic            ovf_s;
  logic [XLEN-1:0] abs_a_s;
  logic [XLEN-1:0] abs_b_s;
  logic [XLEN-1:0] special_res_s;
  logic [XLEN:0]   upper_s;
  logic            ge_s;
  logic [XLEN-1:0] rem_next_s;
  logic [XLEN-1:0] quo_next_s;
  logic [XLEN-1:0] quo_fin_s;
  logic [XLEN-1:0] rem_fin_s;
  logic [XLEN-1:0] fin_res_s;

  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign out_valid = out_valid_r;
  assign result    = result_r;

  // Operand conditioning and special-case detection at the accept edge
  always_comb begin
    signed_s   = ~op[0];
    div_zero_s = (b == 32'd0);
    ovf_s      = signed_s && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (signed_s && a[XLEN-1]) begin
      abs_a_s = 32'd0 - a;
    end else begin
      abs_a_s = a;
    end
    if (signed_s && b[XLEN-1]) begin
      abs_b_s = 32'd0 - b;
    end else begin
      abs_b_s = b;
    end
    if (div_zero_s) begin
      special_res_s = op[1] ? a : 32'hFFFF_FFFF;
    end else begin
      special_res_s = op[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One restoring step; upper_s keeps the bit shifted out of the remainder
  always_comb begin
    upper_s = {rem_r, quo_r[XLEN-1]};
    ge_s    = (upper_s >= {1'b0, dvsr_r});
    if (ge_s) begin
      rem_next_s = upper_s[XLEN-1:0] - dvsr_r;
    end else begin
      rem_next_s = upper_s[XLEN-1:0];
    end
    quo_next_s = {quo_r[XLEN-2:0], ge_s};
    quo_fin_s  = qsign_r ? (32'd0 - quo_next_s) : quo_next_s;
    rem_fin_s  = rsign_r ? (32'd0 - rem_next_s) : rem_next_s;
    fin_res_s  = op_r[1] ? rem_fin_s : quo_fin_s;
  end

  // Control FSM and datapath registers; reset, then kill, take priority
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      count_r     <= 5'd0;
      op_r        <= 2'd0;
      rem_r       <= 32'd0;
      quo_r       <= 32'd0;
      dvsr_r      <= 32'd0;
      qsign_r     <= 1'b0;
      rsign_r     <= 1'b0;
      result_r    <= 32'd0;
      out_valid_r <= 1'b0;
    end else if (kill) begin
      state_r     <= IDLE;
      count_r     <= 5'd0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_r    <= op;
            rem_r   <= 32'd0;
            quo_r   <= abs_a_s;
            dvsr_r  <= abs_b_s;
            qsign_r <= signed_s & (a[XLEN-1] ^ b[XLEN-1]);
            rsign_r <= signed_s & a[XLEN-1];
            count_r <= 5'd0;
            if (div_zero_s || ovf_s) begin
              result_r    <= special_res_s;
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end else begin
              state_r <= CALC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          rem_r   <= rem_next_s;
          quo_r   <= quo_next_s;
          count_r <= count_r + 5'd1;
          if (count_r == 5'd31) begin
            result_r    <= fin_res_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= CALC;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected results, latency,
// handshake hold, kill and mid-operation reset checks.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_cmp;
  int n_err;
  logic [31:0] exp_q[$];

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .kill(kill), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model built from language operators
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int sx;
    int sy;
    sx = int'(x);
    sy = int'(y);
    if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'b00:   return 32'(sx / sy);
      2'b01:   return x / y;
      2'b10:   return 32'(sx % sy);
      default: return x % y;
    endcase
  endfunction

  // Called at posedge+1; accept happens at the next edge, inputs then scrambled
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    exp_q.push_back(exp);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 2'($urandom_range(0, 3));
  endtask

  task automatic finish_op(input int exp_lat, input int hold);
    int lat;
    logic [31:0] exp;
    logic [31:0] held;
    lat = 0;
    if (exp_lat > 0) chk("busy_in_calc", {31'd0, busy}, 32'd1);
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency_edges", 32'(lat), 32'(exp_lat));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    chk("result", result, exp);
    held = result;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_result", result, held);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("taken_valid", {31'd0, out_valid}, 32'd0);
    chk("taken_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp, input int lat, input int hold);
    start_op(o, x, y, exp);
    finish_op(lat, hold);
  endtask

  task automatic no_valid_for(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] dummy;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    op = 2'd0;
    a = 32'd0;
    b = 32'd0;
    kill = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(2'b00, 32'd100, 32'd7, 32'h0000_000E, 32, 0);
    run(2'b10, 32'd100, 32'd7, 32'h0000_0002, 32, 0);
    run(2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32, 0);
    run(2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32, 0);
    run(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0);
    run(2'b11, 32'd5, 32'd0, 32'h0000_0005, 0, 0);
    run(2'b00, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 0, 0);
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0);
    run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32, 0);
    run(2'b01, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32, 5);
    run(2'b11, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32, 0);

    // Kill 10 cycles into a DIV
    start_op(2'b00, 32'd1000, 32'd3, 32'd333);
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    dummy = exp_q.pop_front();
    chk("kill_valid", {31'd0, out_valid}, 32'd0);
    chk("kill_in_ready", {31'd0, in_ready}, 32'd1);
    no_valid_for("kill_no_stale_valid", 40);
    run(2'b01, 32'd1000, 32'd3, 32'h0000_014D, 32, 0);

    // Kill and out_ready together in DONE
    start_op(2'b01, 32'd9, 32'd0, 32'hFFFF_FFFF);
    kill = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    out_ready = 1'b0;
    dummy = exp_q.pop_front();
    chk("kill_done_valid", {31'd0, out_valid}, 32'd0);
    chk("kill_done_busy", {31'd0, busy}, 32'd0);

    // Reset 20 cycles into an op
    start_op(2'b00, 32'd12345, 32'd67, 32'd184);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dummy = exp_q.pop_front();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    no_valid_for("rst_no_stale_valid", 40);

    // Random operands against the reference model
    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 4 == 3) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i == 5) rb = 32'd0;
      if (i % 2 == 1) ra = 32'(0) - ra;
      run(ro, ra, rb, ref_div(ro, ra, rb), (rb == 32'd0) ? 0 : 32, i % 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
